// File: rtl/qeciphy_crc16_pkg.sv
// CRC-16/IBM-3740 shared definitions.
// Polynomial, default seed, byte step and FSM states.
package qeciphy_crc16_pkg;

  localparam logic [15:0] CRC16_POLY         = 16'h1021;
  localparam logic [15:0] CRC16_INIT_DEFAULT = 16'hFFFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } crc_state_t;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = (c << 1) ^ CRC16_POLY;
      else       c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/qeciphy_crc16_beat.sv
// One beat of CRC-16 update over byte-masked data.
// Byte 0 sits in the top byte lane and is folded first.
module qeciphy_crc16_beat
  import qeciphy_crc16_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [15:0]         crc,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  output logic [15:0]         crc_next
);

  localparam int NB = DATA_W / 8;

  // Chain of masked byte steps, byte 0 first.
  always_comb begin
    crc_next = crc;
    for (int b = 0; b < NB; b++) begin
      if (keep[NB-1-b]) begin
        crc_next = crc16_byte(crc_next, data[DATA_W-1-8*b -: 8]);
      end
    end
  end

endmodule

// File: rtl/qeciphy_crc16_stream.sv
// Streaming CRC-16/IBM-3740 generator and checker.
// Accumulates multi-beat frames, flags keep violations.
module qeciphy_crc16_stream
  import qeciphy_crc16_pkg::*;
#(
  parameter int          DATA_W     = 64,
  parameter int          FRAME_MODE = 1,
  parameter logic [15:0] INIT       = CRC16_INIT_DEFAULT,
  parameter logic [15:0] XOROUT     = 16'h0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W-1:0]   tdata_i,
  input  logic [DATA_W/8-1:0] tkeep_i,
  input  logic                tvalid_i,
  input  logic                tlast_i,
  input  logic [15:0]         crc_exp_i,
  output logic [15:0]         crc_o,
  output logic                crc_valid_o,
  output logic                crc_match_o,
  output logic                proto_err_o
);

  localparam int NB = DATA_W / 8;

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
      $error("DATA_W must be a non-zero multiple of 8");
    end
  endgenerate

  crc_state_t  state;
  logic [15:0] crc_run;
  logic [15:0] crc_seed;
  logic [15:0] crc_beat;
  logic [15:0] crc_final;
  logic        is_final;
  logic [NB-1:0] keep_inv;
  logic [NB-1:0] keep_inv_p1;
  logic        keep_full;
  logic        keep_prefix;
  logic        keep_viol;

  assign is_final  = (FRAME_MODE != 0) ? tlast_i : 1'b1;
  assign crc_seed  = (state == IDLE) ? INIT : crc_run;
  assign crc_final = crc_beat ^ XOROUT;

  // A legal last-beat keep has only low-order zeros, so its
  // inverse is a run of low ones: x & (x + 1) == 0.
  assign keep_inv    = ~tkeep_i;
  assign keep_inv_p1 = keep_inv + NB'(1);
  assign keep_full   = &tkeep_i;
  assign keep_prefix = ((keep_inv & keep_inv_p1) == '0);
  assign keep_viol   = is_final ? ~keep_prefix : ~keep_full;

  qeciphy_crc16_beat #(
    .DATA_W (DATA_W)
  ) u_beat (
    .crc      (crc_seed),
    .data     (tdata_i),
    .keep     (tkeep_i),
    .crc_next (crc_beat)
  );

  // Frame FSM and running CRC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      crc_run <= INIT;
    end else if (tvalid_i) begin
      if (is_final) begin
        state   <= IDLE;
        crc_run <= INIT;
      end else begin
        state   <= ACCUM;
        crc_run <= crc_beat;
      end
    end
  end

  // Registered result, compare and error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_o       <= 16'h0000;
      crc_valid_o <= 1'b0;
      crc_match_o <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      crc_valid_o <= 1'b0;
      proto_err_o <= tvalid_i & keep_viol;
      if (tvalid_i && is_final) begin
        crc_o       <= crc_final;
        crc_match_o <= (crc_final == crc_exp_i);
        crc_valid_o <= 1'b1;
      end
    end
  end

endmodule
